// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch prefetch buffer.
//   fetch_state_t    : request sequencer state encoding (IDLE, REQ, DISCARD)
//   fetch_entry_t    : one buffered fetch entry {pc, instr}
//   RESET_PC_DEFAULT : default first fetch address
//   NOP_INSTR        : instruction presented when no entry is valid
package fetch_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t IDLE    = 2'd0;
    localparam fetch_state_t REQ     = 2'd1;
    localparam fetch_state_t DISCARD = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO of fetch entries.
//   clk, rst        : clock, asynchronous active-low reset
//   clear           : empties the FIFO; wins over push and pop
//   push, wdata     : write an entry (accepted when not full, or full with same-cycle pop)
//   pop             : consume the head entry (ignored when empty)
//   rdata           : head entry (combinational)
//   count/empty/full: occupancy status
module prefetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  fetch_entry_t               wdata,
    input  logic                       pop,
    output fetch_entry_t               rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           push_en, pop_en;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign pop_en  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_en = push && (!full || pop_en);
    assign rdata   = mem[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push_en) - CW'(pop_en);
        end
    end

    always_ff @(posedge clk) begin
        if (push_en && !clear) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Prefetch buffer between instruction memory and the fetch/decode register.
// Sequences the fetch PC over a one-outstanding req/ack handshake, buffers
// returned words and presents the head as {pc_f, instr_f, pc_plus_4_f}.
//   clk, rst                   : clock, asynchronous active-low reset
//   stall_f                    : hold the head entry
//   redirect_valid/redirect_pc : taken branch/jump; flushes buffer and refetches
//   instr_valid/instr_f/pc_f/pc_plus_4_f : head entry (combinational)
//   imem_req/imem_addr         : registered memory request
//   imem_ack/imem_rdata        : one-cycle response strobe and data
//   stat_discard/stat_starve   : saturating statistics, built only when
//                                FETCH_PREFETCH_STATS_EN is defined, else 0
module fetch_prefetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_f,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] pc_plus_4_f,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [15:0] stat_discard,
    output logic [15:0] stat_starve
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_t  state_q, state_d;
    logic [31:0]   next_pc_q, next_pc_d;
    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;

    fetch_entry_t  head, push_entry;
    logic [CW-1:0] fifo_count, count_after;
    logic          fifo_empty, fifo_full;
    logic          push, pop;

    assign pop        = !fifo_empty && !stall_f && !redirect_valid;
    assign push       = (state_q == REQ) && imem_ack && !redirect_valid;
    assign push_entry = '{pc: addr_q, instr: imem_rdata};
    assign count_after = fifo_count + CW'(push) - CW'(pop);

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (redirect_valid),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        state_d   = state_q;
        next_pc_d = next_pc_q;
        req_d     = req_q;
        addr_d    = addr_q;
        if (redirect_valid) begin
            next_pc_d = redirect_pc;
            case (state_q)
                IDLE: begin
                    req_d   = 1'b1;
                    addr_d  = redirect_pc;
                    state_d = REQ;
                end
                REQ, DISCARD: begin
                    if (imem_ack) begin
                        // Response belongs to the old path; refetch immediately.
                        req_d   = 1'b1;
                        addr_d  = redirect_pc;
                        state_d = REQ;
                    end else begin
                        state_d = DISCARD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_full) begin
                        req_d   = 1'b1;
                        addr_d  = next_pc_q;
                        state_d = REQ;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        next_pc_d = addr_q + 32'd4;
                        if (count_after < CW'(DEPTH)) begin
                            addr_d = addr_q + 32'd4;
                        end else begin
                            req_d   = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
                DISCARD: begin
                    if (imem_ack) begin
                        req_d   = 1'b1;
                        addr_d  = next_pc_q;
                        state_d = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            next_pc_q <= RESET_PC;
            req_q     <= 1'b0;
            addr_q    <= 32'h0;
        end else begin
            state_q   <= state_d;
            next_pc_q <= next_pc_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = !fifo_empty;
    assign instr_f     = fifo_empty ? NOP_INSTR : head.instr;
    assign pc_f        = fifo_empty ? 32'h0 : head.pc;
    assign pc_plus_4_f = pc_f + 32'd4;

`ifdef FETCH_PREFETCH_STATS_EN
    logic [15:0] discard_q, starve_q;
    logic        ack_dropped;

    assign ack_dropped = imem_ack && ((state_q == DISCARD) || (state_q == REQ && redirect_valid));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            discard_q <= 16'h0;
            starve_q  <= 16'h0;
        end else begin
            if (ack_dropped && discard_q != 16'hFFFF) discard_q <= discard_q + 16'd1;
            if (!stall_f && fifo_empty && starve_q != 16'hFFFF) starve_q <= starve_q + 16'd1;
        end
    end

    assign stat_discard = discard_q;
    assign stat_starve  = starve_q;
`else
    assign stat_discard = 16'h0;
    assign stat_starve  = 16'h0;
`endif

endmodule

// File: doc/fetch_prefetch_buffer.md
Name: fetch_prefetch_buffer

Overview:
- Sits upstream of the fetch/decode pipeline register of the 5-stage MIPS core.
- Owns the PC sequencing towards a multi-cycle instruction memory using a req/ack handshake.
- Buffers returned instructions in a small FIFO and hands {pc, instr, pc+4} to the fetch stage.
- Honours stall_f from the hazard unit and branch/jump redirects resolved in decode.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall_f  in  1  hazard-unit stall; head entry is held, not consumed.
- redirect_valid  in  1  taken branch/jump in decode this cycle.
- redirect_pc  in  32  new fetch target, word aligned.
- instr_valid  out  1  head entry valid.
- instr_f  out  32  head instruction.
- pc_f  out  32  head PC.
- pc_plus_4_f  out  32  head PC + 4.
- imem_req  out  1  memory request.
- imem_addr  out  32  request address, registered.
- imem_ack  in  1  one-cycle response strobe; imem_rdata valid this cycle.
- imem_rdata  in  32  returned instruction word.
- stat_discard  out  16  discarded-response counter (see Optional Feature).
- stat_starve  out  16  starve-cycle counter (see Optional Feature).

Behaviour:
- Reset (rst=0, async): FIFO empty, state IDLE, next_pc=RESET_PC, imem_req=0, imem_addr=0, instr_valid=0, stat counters=0.
- Head outputs are combinational from the FIFO head. With FIFO empty: instr_valid=0 and instr_f=0 (nop).
- Pop when instr_valid && !stall_f && !redirect_valid.
- Handshake:
  - At most one request is outstanding.
  - imem_req and imem_addr stay stable until the imem_ack cycle.
  - A request can never be withdrawn.
- States:
  - IDLE: if count<DEPTH, assert req with addr=next_pc and go to REQ.
  - REQ: on ack, push {imem_addr, imem_rdata} and set next_pc=imem_addr+4. If post-push count<DEPTH (counting a same-cycle pop), keep req=1 with addr=imem_addr+4 (zero-bubble streaming); otherwise drop req and go to IDLE.
  - DISCARD: req is held. On ack, drop the data, issue req at next_pc (the redirect target), and go to REQ.
- Redirect has priority over push and pop in the same cycle:
  - FIFO is cleared and next_pc=redirect_pc.
  - From IDLE: go to REQ at redirect_pc next cycle.
  - From REQ without ack: go to DISCARD.
  - From REQ with ack in the same cycle: drop the data and go to REQ at redirect_pc.
  - Redirect while already in DISCARD: update next_pc only.
- Full FIFO: no request is issued; an in-flight response always has room because issue requires count<DEPTH.
- Simultaneous push and pop with a full FIFO is legal; count is unchanged.
- Pointers wrap modulo DEPTH. PC arithmetic is 32-bit and wraps at 2^32.
- Latency: minimum 2 cycles from imem_ack to the instruction being poppable (push cycle, then visible at head).

Optional Feature:
- Macro: FETCH_PREFETCH_STATS_EN.
- Defined:
  - stat_discard increments on each ack dropped because of a redirect.
  - stat_starve increments each cycle with !stall_f && !instr_valid.
  - Both counters saturate at 16'hFFFF.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Shared package fetch_pkg:
  - fetch_state_t enum {IDLE, REQ, DISCARD}.
  - fetch_entry_t struct {pc[31:0], instr[31:0]}.
  - RESET_PC_DEFAULT constant.
  - NOP_INSTR = 32'h0.
- Sub-module prefetch_fifo: parameterised sync FIFO of fetch_entry_t with push, pop, clear, count, empty and full.
  - Clear has priority over push.
  - Same-cycle pop+push is allowed when full.

Test Plan:
- Reset/stream: release rst, memory acks 1 cycle after each req → addresses 0,4,8,C… issued back-to-back; instr_valid first rises the cycle after the first push, and pc_f sequence is 0,4,8.
- Backpressure: hold stall_f=1 for 10 cycles while streaming → exactly DEPTH=4 entries buffered, imem_req=0; pc_f stays 0 until stall drops, then 4,8,C resume with no loss.
- Redirect mid-request: req at 0x10 outstanding, redirect_pc=0x100, ack arrives 3 cycles later with 0xDEADBEEF → data discarded, FIFO empty, next req addr=0x100, stat_discard=1 (macro on).
- Redirect+ack same cycle: ack for 0x20 coincides with redirect to 0x200 → 0x20 word never appears at the head; next req at 0x200.
- Async reset mid-operation: drop rst while req=1 and FIFO has 3 entries → same cycle: req=0, instr_valid=0; after release, first req addr=RESET_PC.
- Wrap/starve: redirect to 0xFFFFFFFC, slow memory (ack after 4 cycles) → sequence 0xFFFFFFFC, 0x00000000; stat_starve counts cycles with instr_valid=0 (macro on), reads 0 with macro off.
